hd_boot_loader: RTL and testbench



---
 rtl/hd_pkg.sv | 19 +
 rtl/hd_boot_loader.sv | 108 ++++++++++
 tb/tb_hd_boot_loader.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hd_pkg.sv
// Shared hard-disk definitions. The disk model, the CPU decoder and the boot
// loader all use these, so they agree on word width, geometry and the halt word.
package hd_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int HD_TRILHAS_BITS = 4;
  localparam int HD_SETORES_BITS = 4;

  // An all-ones word marks the end of a boot program on disk.
  localparam logic [DATA_WIDTH-1:0] HALT_WORD = '1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPTURE,
    DONE
  } loader_state_t;

endpackage

// File: rtl/hd_boot_loader.sv
// Copies one hard-disk track, sector by sector, into instruction memory.
// The copy ends on the halt word or the last sector, then done pulses once.
module hd_boot_loader #(
  parameter int DATA_WIDTH      = hd_pkg::DATA_WIDTH,
  parameter int HD_TRILHAS_BITS = hd_pkg::HD_TRILHAS_BITS,
  parameter int HD_SETORES_BITS = hd_pkg::HD_SETORES_BITS,
  parameter int MEM_ADDR_BITS   = 10
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [HD_TRILHAS_BITS-1:0] trilha_in,
  input  logic [MEM_ADDR_BITS-1:0]   mem_base,
  input  logic [DATA_WIDTH-1:0]      hdData,
  output logic [HD_TRILHAS_BITS-1:0] trilha,
  output logic [HD_SETORES_BITS-1:0] setor,
  output logic                       hdRead,
  output logic                       memWrite,
  output logic [MEM_ADDR_BITS-1:0]   memAddr,
  output logic [DATA_WIDTH-1:0]      memData,
  output logic                       busy,
  output logic                       done,
  output logic [HD_SETORES_BITS:0]   words_loaded
);
  import hd_pkg::*;

  loader_state_t state, stateNext;

  logic [MEM_ADDR_BITS-1:0] addr;
  logic [HD_SETORES_BITS:0] count;
  logic                     isHalt;
  logic                     lastSetor;

  assign isHalt    = &hdData;
  assign lastSetor = &setor;
  assign memAddr   = addr;
  assign memData   = hdData;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      trilha       <= '0;
      setor        <= '0;
      addr         <= '0;
      count        <= '0;
      words_loaded <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (start) begin
            trilha <= trilha_in;
            setor  <= '0;
            addr   <= mem_base;
            count  <= '0;
          end
        end
        CAPTURE: begin
          count <= count + 1'b1;
          // On the final word setor and addr freeze, so setor never wraps.
          if (!isHalt && !lastSetor) begin
            setor <= setor + 1'b1;
            addr  <= addr + 1'b1;
          end
        end
        DONE:    words_loaded <= count;
        default: ;
      endcase
    end
  end

  always_comb begin
    stateNext = state;
    hdRead    = 1'b0;
    busy      = 1'b0;
    memWrite  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) stateNext = READ;
      end
      READ: begin
        hdRead    = 1'b1;
        busy      = 1'b1;
        stateNext = CAPTURE;
      end
      CAPTURE: begin
        hdRead    = 1'b1;
        busy      = 1'b1;
        memWrite  = 1'b1;
        stateNext = (isHalt || lastSetor) ? DONE : READ;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    // A reset cycle must never write memory or signal completion.
    if (reset) begin
      hdRead   = 1'b0;
      busy     = 1'b0;
      memWrite = 1'b0;
      done     = 1'b0;
    end
  end

endmodule

// File: tb/tb_hd_boot_loader.sv
// Testbench for hd_boot_loader: a disk model feeds tracks, a scoreboard
// checks every memory write (address, data, cycle) and the done timing.
module tb_hd_boot_loader;
  import hd_pkg::*;

  logic        clock;
  logic        reset;
  logic        start;
  logic [3:0]  trilha_in;
  logic [9:0]  mem_base;
  logic [31:0] hdData;
  logic [3:0]  trilha;
  logic [3:0]  setor;
  logic        hdRead;
  logic        memWrite;
  logic [9:0]  memAddr;
  logic [31:0] memData;
  logic        busy;
  logic        done;
  logic [4:0]  words_loaded;

  logic [31:0] hdMem [16][16];

  int cycleCnt;
  int checks;
  int errors;
  int doneCount;
  int expDone;
  bit pendingDone;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    logic [3:0] track;
    logic [9:0] base;
    int         expWords;
    logic [3:0] expSetor;
  } vec_t;
  vec_t vecs[4];

  hd_boot_loader dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .trilha_in   (trilha_in),
    .mem_base    (mem_base),
    .hdData      (hdData),
    .trilha      (trilha),
    .setor       (setor),
    .hdRead      (hdRead),
    .memWrite    (memWrite),
    .memAddr     (memAddr),
    .memData     (memData),
    .busy        (busy),
    .done        (done),
    .words_loaded(words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // Disk model: the word at (trilha, setor) is registered on a read edge.
  always @(posedge clock) if (hdRead) hdData <= hdMem[trilha][setor];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clock);
      if (memWrite) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write memWrite=1 expected=0 addr=%0d", memAddr);
        end else begin
          wr_t e;
          e = sb.pop_front();
          checkOutput("wr_addr", 32'(memAddr), 32'(e.addr));
          checkOutput("wr_data", memData, e.data);
          checkOutput("wr_cycle", 32'(cycleCnt), 32'(e.cyc));
        end
      end
      if (done) begin
        if (!pendingDone) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done done=1 expected=0");
        end else begin
          checkOutput("done_cycle", 32'(cycleCnt), 32'(expDone));
        end
        pendingDone = 1'b0;
        doneCount++;
      end
    end
  endtask

  // Call at a negedge; start is sampled at the next posedge (edge E).
  task automatic applyStimulus(input logic [3:0] t, input logic [9:0] b);
    int e;
    int n;
    e = cycleCnt + 1;
    n = 0;
    start     = 1'b1;
    trilha_in = t;
    mem_base  = b;
    for (int s = 0; s < 16; s++) begin
      wr_t w;
      w.addr = b + 10'(s);
      w.data = hdMem[t][s];
      w.cyc  = e + 2 * s + 1;
      sb.push_back(w);
      n = s + 1;
      if (hdMem[t][s] == HALT_WORD) break;
    end
    expDone     = e + 2 * n;
    pendingDone = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("busy_in_read", 32'(busy), 32'd1);
    checkOutput("hdRead_in_read", 32'(hdRead), 32'd1);
    checkOutput("trilha_latched", 32'(trilha), 32'(t));
    checkOutput("setor_start", 32'(setor), 32'd0);
  endtask

  task automatic waitDone(input string name);
    int startCount;
    bit got;
    startCount = doneCount;
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clock);
      got = (doneCount > startCount);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout done=0 expected=1", name);
    end
  endtask

  initial begin
    int baseDone;
    reset     = 1'b1;
    start     = 1'b0;
    trilha_in = '0;
    mem_base  = '0;

    for (int t = 0; t < 16; t++)
      for (int s = 0; s < 16; s++)
        hdMem[t][s] = 32'hA000_0000 | (t << 8) | s;
    hdMem[0][0] = 32'h2402_00C8;
    hdMem[0][1] = 32'h7C02_0000;
    hdMem[0][2] = HALT_WORD;
    hdMem[2][0] = HALT_WORD;

    vecs[0] = '{track: 4'd0, base: 10'd0,    expWords: 3,  expSetor: 4'd2};
    vecs[1] = '{track: 4'd2, base: 10'd100,  expWords: 1,  expSetor: 4'd0};
    vecs[2] = '{track: 4'd5, base: 10'd0,    expWords: 16, expSetor: 4'd15};
    vecs[3] = '{track: 4'd0, base: 10'd1022, expWords: 3,  expSetor: 4'd2};

    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_trilha", 32'(trilha), 32'd0);
    checkOutput("rst_setor", 32'(setor), 32'd0);
    checkOutput("rst_memAddr", 32'(memAddr), 32'd0);
    checkOutput("rst_words", 32'(words_loaded), 32'd0);
    checkOutput("rst_hdRead", 32'(hdRead), 32'd0);
    checkOutput("rst_memWrite", 32'(memWrite), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    fork
      monitor();
    join_none

    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].track, vecs[i].base);
      waitDone("load");
      @(negedge clock);
      checkOutput("words_loaded", 32'(words_loaded), 32'(vecs[i].expWords));
      checkOutput("setor_end", 32'(setor), 32'(vecs[i].expSetor));
      checkOutput("trilha_end", 32'(trilha), 32'(vecs[i].track));
      checkOutput("busy_idle", 32'(busy), 32'd0);
      checkOutput("sb_drained", 32'(sb.size()), 32'd0);
      repeat (3) @(negedge clock);
    end

    // Reset during the second CAPTURE of a track-0 load.
    baseDone = doneCount;
    applyStimulus(4'd0, 10'd0);
    @(negedge clock);
    @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    checkOutput("midrst_memWrite", 32'(memWrite), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_pending", 32'(sb.size()), 32'd2);
    sb.delete();
    pendingDone = 1'b0;
    @(negedge clock);
    checkOutput("postrst_hdRead", 32'(hdRead), 32'd0);
    checkOutput("postrst_busy", 32'(busy), 32'd0);
    checkOutput("postrst_setor", 32'(setor), 32'd0);
    checkOutput("postrst_memAddr", 32'(memAddr), 32'd0);
    checkOutput("postrst_words", 32'(words_loaded), 32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    checkOutput("midrst_no_done", 32'(doneCount), 32'(baseDone));

    // start pulsed while busy must be ignored.
    baseDone = doneCount;
    applyStimulus(4'd0, 10'd0);
    @(negedge clock);
    start     = 1'b1;
    trilha_in = 4'd5;
    mem_base  = 10'd500;
    @(negedge clock);
    start = 1'b0;
    waitDone("busy_start");
    @(negedge clock);
    checkOutput("busy_words", 32'(words_loaded), 32'd3);
    checkOutput("busy_trilha", 32'(trilha), 32'd0);
    repeat (40) @(negedge clock);
    checkOutput("busy_one_done", 32'(doneCount), 32'(baseDone + 1));
    checkOutput("busy_sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
